// File: rtl/audio_bank_buffer_pkg.sv
// audio_bank_buffer_pkg: shared sizing for the audio sample buffer.
// The bank count and bank size together set the sample RAM address layout.
package audio_bank_buffer_pkg;
   localparam int AUDIO_BANKS          = 4;
   localparam int AUDIO_BANK_ADDR_BITS = 9;
   localparam int BANK_PTR_BITS        = $clog2(AUDIO_BANKS);
endpackage

// File: rtl/audio_bank_ram.sv
// audio_bank_ram: simple dual-port sample RAM with a registered read port.
// The array has no reset so that it maps onto block RAM.
module audio_bank_ram #(
   parameter int ADDR_BITS  = 11,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_BITS-1:0]  i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_BITS-1:0]  i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   logic [DATA_WIDTH-1:0] r_mem [1<<ADDR_BITS];
   logic [DATA_WIDTH-1:0] r_q;
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_q <= r_mem[i_raddr];
   end
   assign o_rdata = r_q;
endmodule

// File: rtl/audio_bank_buffer.sv
// audio_bank_buffer: N-bank circular sample buffer between file reader and codec.
// Owns the sample RAM, bank pointers, fill accounting and overflow/underrun reporting.
module audio_bank_buffer
   import audio_bank_buffer_pkg::*;
#(
   parameter int NUM_BANKS         = AUDIO_BANKS,
   parameter int BANK_ADDR_BITS    = AUDIO_BANK_ADDR_BITS,
   parameter int DATA_WIDTH        = 8,
   parameter int UNDERRUN_CNT_BITS = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         wr_en,
   input  logic [BANK_ADDR_BITS-1:0]    wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         wr_bank_done,
   output logic                         wr_ready,
   input  logic [BANK_ADDR_BITS-1:0]    rd_addr,
   output logic [DATA_WIDTH-1:0]        rd_data,
   input  logic                         rd_bank_done,
   output logic                         rd_valid,
   output logic [$clog2(NUM_BANKS):0]   fill_count,
   output logic                         overflow,
   output logic [UNDERRUN_CNT_BITS-1:0] underrun_count
);
   localparam int PB = $clog2(NUM_BANKS);
   localparam int FB = PB + 1;
   localparam int UB = UNDERRUN_CNT_BITS;
   logic [PB-1:0]         r_wr_ptr, r_rd_ptr;
   logic [FB-1:0]         r_fill;
   logic                  r_ovf;
   logic [UB-1:0]         r_und;
   logic                  r_rd_live;
   logic                  w_wr_ready, w_rd_valid, w_wr_acc, w_rd_acc;
   logic [DATA_WIDTH-1:0] w_ram_q;
   assign w_wr_ready = r_fill < FB'(NUM_BANKS);
   assign w_rd_valid = r_fill != '0;
   assign w_wr_acc   = wr_bank_done & w_wr_ready;
   assign w_rd_acc   = rd_bank_done & w_rd_valid;
   audio_bank_ram #(.ADDR_BITS(PB + BANK_ADDR_BITS), .DATA_WIDTH(DATA_WIDTH)) u_ram (
      .clk     (clk),
      .i_we    (wr_en & (w_wr_ready | flush)),
      .i_waddr ({r_wr_ptr, wr_addr}),
      .i_wdata (wr_data),
      .i_raddr ({r_rd_ptr, rd_addr}),
      .o_rdata (w_ram_q)
   );
   // Acceptance uses the pre-edge fill, so a read cannot rescue a write when full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_fill    <= '0;
         r_ovf     <= 1'b0;
         r_und     <= '0;
         r_rd_live <= 1'b0;
      end else if (flush) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_fill    <= '0;
         r_ovf     <= 1'b0;
         r_und     <= '0;
         r_rd_live <= 1'b0;
      end else begin
         r_wr_ptr  <= r_wr_ptr + PB'(w_wr_acc);
         r_rd_ptr  <= r_rd_ptr + PB'(w_rd_acc);
         r_fill    <= r_fill + FB'(w_wr_acc) - FB'(w_rd_acc);
         r_ovf     <= r_ovf | ((wr_en | wr_bank_done) & ~w_wr_ready);
         r_und     <= (rd_bank_done & ~w_rd_valid & ~&r_und) ? r_und + UB'(1) : r_und;
         r_rd_live <= w_rd_valid;
      end
   end
   // Reads issued while empty yield silence rather than stale RAM contents.
   assign rd_data        = r_rd_live ? w_ram_q : '0;
   assign wr_ready       = w_wr_ready;
   assign rd_valid       = w_rd_valid;
   assign fill_count     = r_fill;
   assign overflow       = r_ovf;
   assign underrun_count = r_und;
endmodule

// File: doc/audio_bank_buffer.md
Name: audio_bank_buffer

Overview:
- Parametrised N-bank circular sample buffer between the FAT32 file reader (producer) and the audio codec (consumer).
- Replaces the fixed two-bank ping-pong scheme, where one select bit and the top RAM address bit chose the bank.
- Owns the sample RAM, the bank pointers and the fill accounting.
- Reports overflow and underrun so the top level can show them on LEDs.

Parameters:
- NUM_BANKS, 4, number of banks; power of two, >= 2.
- BANK_ADDR_BITS, 9, address bits within one bank (512 entries = one SD block).
- DATA_WIDTH, 8, bits per RAM entry.
- UNDERRUN_CNT_BITS, 16, width of the saturating underrun counter.

Ports:
- clk  in  1  system clock (200 MHz).
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of buffer state.
- wr_en  in  1  write strobe.
- wr_addr  in  BANK_ADDR_BITS  offset within the current write bank.
- wr_data  in  DATA_WIDTH  write data.
- wr_bank_done  in  1  pulse: current write bank is complete.
- wr_ready  out  1  a free bank is available for writing.
- rd_addr  in  BANK_ADDR_BITS  offset within the current read bank.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_bank_done  in  1  pulse: current read bank is consumed.
- rd_valid  out  1  a filled bank is available for reading.
- fill_count  out  $clog2(NUM_BANKS)+1  number of filled banks.
- overflow  out  1  sticky: a write or wr_bank_done arrived while full.
- underrun_count  out  UNDERRUN_CNT_BITS  saturating count of rd_bank_done pulses while empty.

Behaviour:
- Reset (async on rst) and flush (sync) both clear state: wr_ptr=0, rd_ptr=0, fill_count=0, overflow=0, underrun_count=0, rd_data=0. RAM contents are not cleared.
- Outputs after reset: wr_ready=1, rd_valid=0.
- wr_ready = (fill_count < NUM_BANKS). rd_valid = (fill_count != 0). Both are combinational from registers.
- Physical RAM address = {bank_ptr, offset}. Pointers are $clog2(NUM_BANKS) bits and wrap modulo NUM_BANKS.
- Write path:
  - wr_en & wr_ready: RAM[{wr_ptr, wr_addr}] <= wr_data on the same edge.
  - wr_en & !wr_ready: write is dropped and overflow is set.
- wr_bank_done:
  - If wr_ready: wr_ptr increments (wrapping).
  - If !wr_ready: ignored and overflow is set.
- rd_bank_done:
  - If rd_valid: rd_ptr increments (wrapping).
  - If !rd_valid: ignored and underrun_count increments, saturating at all-ones.
- Fill accounting:
  - Accepted wr_bank_done alone: fill_count +1.
  - Accepted rd_bank_done alone: fill_count -1.
  - Both accepted in the same cycle: fill_count unchanged, both pointers advance.
- All acceptance decisions use the pre-edge fill_count. When full, a simultaneous rd_bank_done does not rescue a wr_bank_done: the write is still rejected and overflow is set.
- Read latency is 1 cycle:
  - rd_data at edge k+1 = RAM[{rd_ptr, rd_addr}] sampled at edge k, if rd_valid was 1 at edge k.
  - Otherwise rd_data = 0 (silence).
- Read-during-write to the same physical address returns old data. In normal operation this cannot happen, because the read and write banks differ whenever rd_valid=1 and wr_ready=1.
- rd_ptr advancing at edge k does not affect the rd_data produced for the address sampled at edge k.
- flush has priority over every other input in the same cycle. wr_en in a flush cycle is still written to RAM but is irrelevant.
- Assert rst mid-bank: the partial bank is discarded and all counters return to reset values.

Decomposition:
- Shared package (globals): AUDIO_BANKS, AUDIO_BANK_ADDR_BITS (replacing BUFFER_ADDR_BITS/RAM_ADDR_BITS), and derived BANK_PTR_BITS = $clog2(AUDIO_BANKS).
- One sub-module: audio_bank_ram.
  - Simple dual-port RAM, one write port and one registered read port.
  - Depth NUM_BANKS<<BANK_ADDR_BITS, width DATA_WIDTH.
  - Must infer block RAM (no reset on the array).
- Pointer and fill logic stay in audio_bank_buffer.

Test Plan (NUM_BANKS=4, BANK_ADDR_BITS=4, DATA_WIDTH=8):
- Reset check: rst pulse -> wr_ready=1, rd_valid=0, fill_count=0, rd_data=0, overflow=0.
- Single bank round trip:
  - Stimulus: write 0x10..0x1F to offsets 0..15, pulse wr_bank_done, then read offsets 0..15.
  - Response: fill_count=1, rd_valid=1. rd_data is 0x10..0x1F, each one cycle after its address. rd_bank_done -> fill_count=0.
- Fill and overflow:
  - Stimulus: complete 4 banks, then wr_en and wr_bank_done.
  - Response: wr_ready=0, fill_count=4, overflow=1, fill_count stays 4. Bank 0 data is unchanged when read back.
- Simultaneous done pulses:
  - At fill_count=2, wr_bank_done & rd_bank_done in the same cycle -> fill_count=2, wr_ptr and rd_ptr both +1.
  - At fill_count=4, the same pair -> fill_count=3, overflow=1.
- Underrun and wrap:
  - Stimulus: three rd_bank_done pulses while empty.
  - Response: underrun_count=3, rd_data=0.
  - Stimulus: run 9 bank round trips.
  - Response: pointers wrap, each bank's data is read back intact.
- Flush mid-stream: at fill_count=3, overflow=1, assert flush concurrently with wr_bank_done -> fill_count=0, overflow=0, pointers=0, rd_valid=0 next cycle.
